// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, special-case constants and op-class decode helpers.
package mdu_pkg;

    typedef enum logic [4:0] {
        OP_MUL    = 5'b01011,
        OP_MULH   = 5'b01100,
        OP_MULHSU = 5'b01101,
        OP_MULHU  = 5'b01110,
        OP_DIV    = 5'b01111,
        OP_DIVU   = 5'b10000,
        OP_REM    = 5'b10001,
        OP_REMU   = 5'b10010
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Constants sized for the widest XLEN; instances slice what they need.
    localparam int unsigned                 MDU_MAX_XLEN = 64;
    localparam logic [MDU_MAX_XLEN-1:0]     MDU_ALL_ONES = '1;
    localparam logic [MDU_MAX_XLEN-1:0]     MDU_MOST_NEG = {1'b1, {(MDU_MAX_XLEN-1){1'b0}}};

    function automatic logic is_m_op(input logic [4:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_m_op = 1'b1;
            default:                          is_m_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input alu_op_e op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_div_op = 1'b1;
            default:                          is_div_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_rem_op(input alu_op_e op);
        case (op)
            OP_REM, OP_REMU: is_rem_op = 1'b1;
            default:         is_rem_op = 1'b0;
        endcase
    endfunction

    function automatic logic signed_a(input alu_op_e op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: signed_a = 1'b1;
            default:                                    signed_a = 1'b0;
        endcase
    endfunction

    function automatic logic signed_b(input alu_op_e op);
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: signed_b = 1'b1;
            default:                         signed_b = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the magnitude datapath: BITS_PER_CYCLE rounds of
// shift/add (multiply) or shift/subtract restoring division.
module mdu_step #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] low_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] low_o
);

    // Multiply: {acc,low} is the product shifting right as multiplier bits retire.
    // Divide:   acc is the partial remainder, low shifts dividend out / quotient in.
    always_comb begin
        logic [XLEN-1:0] acc;
        logic [XLEN-1:0] low;
        logic [XLEN:0]   sum;
        acc = acc_i;
        low = low_i;
        sum = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div_i) begin
                sum = {acc, low[XLEN-1]} - {1'b0, opnd_i};
                if (!sum[XLEN]) begin
                    acc = sum[XLEN-1:0];
                    low = {low[XLEN-2:0], 1'b1};
                end else begin
                    acc = {acc[XLEN-2:0], low[XLEN-1]};
                    low = {low[XLEN-2:0], 1'b0};
                end
            end else begin
                sum = {1'b0, acc} + (low[0] ? {1'b0, opnd_i} : (XLEN+1)'(0));
                acc = sum[XLEN:1];
                low = {sum[0], low[XLEN-1:1]};
            end
        end
        acc_o = acc;
        low_o = low;
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV M-extension multiply/divide unit (IDLE -> CALC -> DONE).
// Define MDU_FUSE_EN to reuse the last MULH*/DIV* result for a matching MUL/REM.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned      ITERS    = XLEN / BITS_PER_CYCLE;
    localparam int unsigned      CNT_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
    localparam logic [XLEN-1:0]  ALL_ONES = MDU_ALL_ONES[XLEN-1:0];
    localparam logic [XLEN-1:0]  MOST_NEG = MDU_MOST_NEG[MDU_MAX_XLEN-1 -: XLEN];

    state_e            state_q, state_d;
    alu_op_e           op_q, op_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   low_q, low_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   step_acc, step_low;

    alu_op_e           in_op;
    logic              accept, in_div, in_rem, a_neg, b_neg, spec_hit;
    logic [XLEN-1:0]   a_mag, b_mag, spec_q, spec_r;

    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, done_res;

`ifdef MDU_FUSE_EN
    logic              fuse_vld_q, fuse_vld_d;
    alu_op_e           fuse_op_q, fuse_op_d;
    logic [XLEN-1:0]   fuse_a_q, fuse_a_d;
    logic [XLEN-1:0]   fuse_b_q, fuse_b_d;
    logic [XLEN-1:0]   fuse_hi_q, fuse_hi_d;
    logic [XLEN-1:0]   fuse_lo_q, fuse_lo_d;
    logic              fuse_hit;
`endif

    mdu_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div_i (is_div_op(op_q)),
        .acc_i    (acc_q),
        .low_i    (low_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .low_o    (step_low)
    );

    // Request decode: operand magnitudes and the two single-cycle special cases.
    always_comb begin
        in_op    = alu_op_e'(alu_op_i);
        accept   = start_i & ~busy_q & is_m_op(alu_op_i) & ~flush_i;
        in_div   = is_div_op(in_op);
        in_rem   = is_rem_op(in_op);
        a_neg    = signed_a(in_op) & src_a_i[XLEN-1];
        b_neg    = signed_b(in_op) & src_b_i[XLEN-1];
        a_mag    = a_neg ? -src_a_i : src_a_i;
        b_mag    = b_neg ? -src_b_i : src_b_i;
        spec_hit = 1'b0;
        spec_q   = ALL_ONES;
        spec_r   = src_a_i;
        if (in_div && (src_b_i == '0)) begin
            spec_hit = 1'b1;
        end else if (in_div && signed_a(in_op) && (src_a_i == MOST_NEG) && (src_b_i == ALL_ONES)) begin
            spec_hit = 1'b1;
            spec_q   = src_a_i;
            spec_r   = '0;
        end
    end

`ifdef MDU_FUSE_EN
    always_comb begin
        fuse_hit = fuse_vld_q && (src_a_i == fuse_a_q) && (src_b_i == fuse_b_q) &&
                   (((in_op == OP_MUL) && ((fuse_op_q == OP_MULH) || (fuse_op_q == OP_MULHSU) ||
                                           (fuse_op_q == OP_MULHU))) ||
                    ((in_op == OP_REM)  && (fuse_op_q == OP_DIV)) ||
                    ((in_op == OP_REMU) && (fuse_op_q == OP_DIVU)));
    end
`endif

    // Sign fix-up of the final iteration's magnitudes.
    always_comb begin
        prod_mag = {step_acc, step_low};
        prod_fix = neg_res_q ? -prod_mag : prod_mag;
        quo_fix  = neg_res_q ? -step_low : step_low;
        rem_fix  = neg_rem_q ? -step_acc : step_acc;
        case (op_q)
            OP_MUL:                        done_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  done_res = prod_fix[2*XLEN-1:XLEN];
            OP_REM, OP_REMU:               done_res = rem_fix;
            default:                       done_res = quo_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        low_d     = low_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        result_d  = result_q;
`ifdef MDU_FUSE_EN
        fuse_vld_d = fuse_vld_q;
        fuse_op_d  = fuse_op_q;
        fuse_a_d   = fuse_a_q;
        fuse_b_d   = fuse_b_q;
        fuse_hi_d  = fuse_hi_q;
        fuse_lo_d  = fuse_lo_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (accept) begin
                    op_d      = in_op;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (spec_hit) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        result_d = in_rem ? spec_r : spec_q;
`ifdef MDU_FUSE_EN
                        fuse_vld_d = 1'b1;
                        fuse_op_d  = in_op;
                        fuse_a_d   = src_a_i;
                        fuse_b_d   = src_b_i;
                        fuse_hi_d  = spec_r;
                        fuse_lo_d  = spec_q;
`endif
                    end
`ifdef MDU_FUSE_EN
                    else if (fuse_hit) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        result_d = (in_op == OP_MUL) ? fuse_lo_q : fuse_hi_q;
                    end
`endif
                    else begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        low_d   = in_div ? a_mag : b_mag;
                        opnd_d  = in_div ? b_mag : a_mag;
`ifdef MDU_FUSE_EN
                        fuse_vld_d = 1'b0;
                        fuse_op_d  = in_op;
                        fuse_a_d   = src_a_i;
                        fuse_b_d   = src_b_i;
`endif
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                low_d = step_low;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    valid_d  = 1'b1;
                    result_d = done_res;
`ifdef MDU_FUSE_EN
                    fuse_vld_d = 1'b1;
                    fuse_hi_d  = is_div_op(op_q) ? rem_fix : prod_fix[2*XLEN-1:XLEN];
                    fuse_lo_d  = is_div_op(op_q) ? quo_fix : prod_fix[XLEN-1:0];
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over everything, including a same-cycle start or completion.
        if (flush_i) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
            cnt_d    = '0;
            result_d = result_q;
`ifdef MDU_FUSE_EN
            fuse_vld_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            low_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
`ifdef MDU_FUSE_EN
            fuse_vld_q <= 1'b0;
            fuse_op_q  <= OP_MUL;
            fuse_a_q   <= '0;
            fuse_b_q   <= '0;
            fuse_hi_q  <= '0;
            fuse_lo_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
`ifdef MDU_FUSE_EN
            fuse_vld_q <= fuse_vld_d;
            fuse_op_q  <= fuse_op_d;
            fuse_a_q   <= fuse_a_d;
            fuse_b_q   <= fuse_b_d;
            fuse_hi_q  <= fuse_hi_d;
            fuse_lo_q  <= fuse_lo_d;
`endif
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule
